uart_mem_bridge: RTL and testbench

Byte-level command bridge between the UART receiver/transmitter and the DDR3 memory device's word port. It assembles host bytes into read and write commands, runs one memory handshake per command, and returns replies over UART. This lets a PC load and inspect DDR3 contents without the on-chip test sequencer. It connects downstream of `uart` (`data_out`, `data_received`, `data_sent`) and upstream of `ddr3_dev` (`addr_i`, `data_i`, `we_i`, `rd_i`, `ack_o`, `data_o`).

---
 rtl/uart_mem_pkg.sv | 24 ++
 rtl/uart_mem_bridge.sv | 132 +++++++++++++
 tb/tb_uart_mem_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_mem_pkg                                                     |
// | Opcodes, reply bytes and FSM states for the UART/memory bridge.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_mem_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    MEM  = 3'd3,
    TX   = 3'd4,
    TXW  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_mem_bridge                                                  |
// | Turns host UART bytes into single-word memory reads and writes.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_mem_bridge
  import uart_mem_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_sent,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        mem_we_o,
  output logic        mem_rd_o,
  input  logic        mem_ack_i,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  state_t      state, state_nxt;
  logic        is_write;
  logic [31:0] addr, wdata, rdata, tcnt;
  logic [1:0]  idx, tx_left;
  logic [7:0]  ovr;
  logic        collecting, timeout, dropping;

  assign collecting = (state == ADDR) || (state == DATA);
  assign timeout    = collecting && (tcnt == 32'(TIMEOUT));
  assign dropping   = (state == MEM) || (state == TX) || (state == TXW);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == OP_WRITE || rx_data == OP_READ) state_nxt = ADDR;
        else                                            state_nxt = TX;
      end
      ADDR: begin
        if (timeout)                    state_nxt = IDLE;
        else if (rx_valid && idx == 2'd3) state_nxt = is_write ? DATA : MEM;
      end
      DATA: begin
        if (timeout)                    state_nxt = IDLE;
        else if (rx_valid && idx == 2'd3) state_nxt = MEM;
      end
      MEM:  if (mem_ack_i) state_nxt = TX;
      TX:   state_nxt = TXW;
      TXW:  if (tx_sent) state_nxt = (tx_left == 2'd0) ? IDLE : TX;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_send  = (state == TX);
    mem_we_o = (state == MEM) && is_write;
    mem_rd_o = (state == MEM) && !is_write;
    busy     = (state != IDLE);
  end

  // rdata doubles as the reply shift register; its top byte is always on tx_data
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write <= 1'b0;
      addr     <= 32'h0;
      wdata    <= 32'h0;
      rdata    <= 32'h0;
      tcnt     <= 32'h0;
      idx      <= 2'd0;
      tx_left  <= 2'd0;
      ovr      <= 8'h0;
    end else begin
      if (!collecting || rx_valid) tcnt <= 32'h0;
      else                         tcnt <= tcnt + 32'h1;

      if (rx_valid && dropping && ovr != 8'hFF) ovr <= ovr + 8'h1;

      case (state)
        IDLE: if (rx_valid) begin
          is_write <= (rx_data == OP_WRITE);
          idx      <= 2'd0;
          if (rx_data != OP_WRITE && rx_data != OP_READ) begin
            rdata   <= {RSP_ERR, 24'h0};
            tx_left <= 2'd0;
          end
        end
        ADDR: if (rx_valid && !timeout) begin
          addr <= {addr[23:0], rx_data};
          idx  <= idx + 2'd1;
        end
        DATA: if (rx_valid && !timeout) begin
          wdata <= {wdata[23:0], rx_data};
          idx   <= idx + 2'd1;
        end
        MEM: if (mem_ack_i) begin
          if (is_write) begin
            rdata   <= {RSP_OK, 24'h0};
            tx_left <= 2'd0;
          end else begin
            rdata   <= mem_data_i;
            tx_left <= 2'd3;
          end
        end
        TXW: if (tx_sent) begin
          rdata   <= {rdata[23:0], 8'h0};
          tx_left <= tx_left - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign tx_data     = rdata[31:24];
  assign mem_addr_o  = {addr[31:2], 2'b00};
  assign mem_data_o  = wdata;
  assign overrun_cnt = ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_mem_bridge                                               |
// | Directed self-checking bench for uart_mem_bridge.                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_sent = 1'b0;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [31:0] mem_data_i = 32'h0;
  logic        mem_we_o, mem_rd_o;
  logic        mem_ack_i = 1'b0;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_tx  = 0;
  int n_req = 0;
  logic req_q = 1'b0;

  uart_mem_bridge #(.TIMEOUT(50)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_sent(tx_sent),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_we_o(mem_we_o), .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Counts transmitted bytes and distinct memory requests
  always @(posedge clk) begin
    req_q <= mem_we_o | mem_rd_o;
    if (tx_send) n_tx <= n_tx + 1;
    if ((mem_we_o | mem_rd_o) && !req_q) n_req <= n_req + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic mem_expect(input string tag, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
    chk($sformatf("%s_we", tag), mem_we_o, we);
    chk($sformatf("%s_rd", tag), mem_rd_o, !we);
    chk($sformatf("%s_addr", tag), mem_addr_o, a);
    if (we) chk($sformatf("%s_wdata", tag), mem_data_o, d);
  endtask

  task automatic mem_ack(input logic [31:0] d);
    mem_data_i = d;
    mem_ack_i  = 1'b1;
    @(negedge clk);
    mem_ack_i  = 1'b0;
    mem_data_i = 32'h0;
  endtask

  // Expect one reply byte; 'now' means tx_send must already be high
  task automatic uart_reply(input string tag, input logic [7:0] exp, input bit now);
    int k = 0;
    if (now) chk($sformatf("%s_now", tag), tx_send, 1'b1);
    while (!tx_send && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s_send", tag), tx_send, 1'b1);
    chk($sformatf("%s_byte", tag), tx_data, exp);
    repeat (3) @(negedge clk);
    chk($sformatf("%s_hold", tag), tx_send, 1'b0);
    tx_sent = 1'b1;
    @(negedge clk);
    tx_sent = 1'b0;
  endtask

  initial begin
    int tx0, req0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_send", tx_send, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_data_o, 32'h0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_rd", mem_rd_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun_cnt, 8'h0);

    // Write 0xDEADBEEF to 0x104, ack after 5 cycles of request
    tx0 = n_tx;
    send_byte(8'h57); send_word(32'h0000_0104); send_word(32'hDEAD_BEEF);
    mem_expect("wr", 1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
    repeat (4) begin
      @(negedge clk);
      chk("wr_hold_we", mem_we_o, 1'b1);
      chk("wr_hold_addr", mem_addr_o, 32'h0000_0104);
    end
    mem_ack(32'h0);
    chk("wr_req_drop", mem_we_o, 1'b0);
    uart_reply("wr_k", 8'h4B, 1'b1);
    chk("wr_idle", busy, 1'b0);
    chk("wr_one_tx", n_tx - tx0, 1);

    // Read from 0x107: low address bits cleared, four reply bytes MSB first
    tx0 = n_tx;
    send_byte(8'h52); send_word(32'h0000_0107);
    mem_expect("rd", 1'b0, 32'h0000_0104, 32'h0);
    repeat (2) @(negedge clk);
    chk("rd_hold", mem_rd_o, 1'b1);
    mem_ack(32'h1234_5678);
    chk("rd_req_drop", mem_rd_o, 1'b0);
    uart_reply("rd_b0", 8'h12, 1'b1);
    uart_reply("rd_b1", 8'h34, 1'b1);
    uart_reply("rd_b2", 8'h56, 1'b1);
    uart_reply("rd_b3", 8'h78, 1'b1);
    chk("rd_idle", busy, 1'b0);
    chk("rd_tx_cnt", n_tx - tx0, 4);

    // Unknown opcode
    req0 = n_req;
    send_byte(8'h41);
    chk("bad_busy", busy, 1'b1);
    chk("bad_no_req", mem_we_o | mem_rd_o, 1'b0);
    uart_reply("bad_q", 8'h3F, 1'b1);
    chk("bad_idle", busy, 1'b0);
    chk("bad_req_cnt", n_req - req0, 0);

    // Timeout after a partial write command
    req0 = n_req;
    tx0  = n_tx;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (45) @(negedge clk);
    chk("tmo_still_busy", busy, 1'b1);
    repeat (10) @(negedge clk);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_no_req", n_req - req0, 0);
    chk("tmo_no_tx", n_tx - tx0, 0);
    send_byte(8'h52); send_word(32'h0000_0010);
    mem_expect("tmo_rd", 1'b0, 32'h0000_0010, 32'h0);
    mem_ack(32'hA5A5_0001);
    uart_reply("tmo_b0", 8'hA5, 1'b1);
    uart_reply("tmo_b1", 8'hA5, 1'b1);
    uart_reply("tmo_b2", 8'h00, 1'b1);
    uart_reply("tmo_b3", 8'h01, 1'b1);
    chk("tmo_rd_idle", busy, 1'b0);

    // Overrun: three bytes while the read ack is stalled
    send_byte(8'h52); send_word(32'h0000_0200);
    mem_expect("ovr_rd", 1'b0, 32'h0000_0200, 32'h0);
    send_byte(8'h57); send_byte(8'h52); send_byte(8'h00);
    chk("ovr_cnt", overrun_cnt, 8'd3);
    chk("ovr_rd_hold", mem_rd_o, 1'b1);
    chk("ovr_addr_hold", mem_addr_o, 32'h0000_0200);
    mem_ack(32'hCAFE_F00D);
    uart_reply("ovr_b0", 8'hCA, 1'b1);
    uart_reply("ovr_b1", 8'hFE, 1'b1);
    uart_reply("ovr_b2", 8'hF0, 1'b1);
    uart_reply("ovr_b3", 8'h0D, 1'b1);
    chk("ovr_idle", busy, 1'b0);
    chk("ovr_cnt_end", overrun_cnt, 8'd3);

    // Reset while a read request is held
    tx0 = n_tx;
    send_byte(8'h52); send_word(32'h0000_0300);
    repeat (10) @(negedge clk);
    chk("rstm_rd_held", mem_rd_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_rd", mem_rd_o, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_addr", mem_addr_o, 32'h0);
    chk("rstm_ovr", overrun_cnt, 8'h0);
    mem_ack(32'h1111_2222);
    repeat (4) @(negedge clk);
    tx_sent = 1'b1;
    @(negedge clk);
    tx_sent = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstm_no_tx", n_tx - tx0, 0);
    chk("rstm_still_idle", busy, 1'b0);
    chk("rstm_tx_data", tx_data, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
